// File: rtl/tipi_link_pkg.sv
// tipi_link_pkg: shared state encoding, register selects and poll interval for the TIPI link master
package tipi_link_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, WBIT, LATCH, LOAD, PRIMEC, RBIT, DONE} state_t;
  localparam logic [1:0] RC = 2'b00;
  localparam logic [1:0] RD = 2'b01;
  localparam logic [1:0] TC = 2'b10;
  localparam logic [1:0] TD = 2'b11;
  localparam int POLL_INTERVAL = 256;
endpackage

// File: rtl/tipi_link_phase_timer.sv
// tipi_link_phase_timer: DIV-cycle down-counter pulsing phase_done on the last clk of each phase
module tipi_link_phase_timer #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic phase_done
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign phase_done = cnt == '0;
  // reload on every state change and at the end of each phase, otherwise count down
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (restart || phase_done) ? W'(DIV - 1) : cnt - 1'b1;
endmodule

// File: rtl/tipi_link_master.sv
// tipi_link_master: drives the TIPI register link pins for byte reads/writes; TIPI_LINK_POLL_EN adds TC polling
module tipi_link_master
  import tipi_link_pkg::*;
#(
  parameter int DIV   = 4,
  parameter int PRIME = 1
) (
  input  logic       clk,
  input  logic       reset,
`ifdef TIPI_LINK_POLL_EN
  input  logic       poll_en,
  output logic       tc_change,
`endif
  input  logic       req,
  input  logic       rt,
  input  logic       cd,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       ack,
  output logic [7:0] rdata,
  output logic       r_clk,
  output logic       r_cd,
  output logic       r_rt,
  output logic       r_le,
  output logic       r_dout,
  input  logic       r_din
);
  localparam int PW = $clog2(2 * PRIME + 17);
  state_t state, state_n;
  logic [PW-1:0] ph, ph_n;
  logic [7:0] sh, go_wdata;
  logic pd, go, go_rt, go_cd, is_poll, bits_last, prime_last, last_sample;

  tipi_link_phase_timer #(.DIV(DIV)) u_timer (
    .clk(clk),
    .reset(reset),
    .restart(state_n != state),
    .phase_done(pd)
  );

  assign bits_last   = ph == PW'(15);
  assign prime_last  = ph == PW'(2 * PRIME - 1);
  assign last_sample = pd && state == RBIT && bits_last;
  assign r_clk = (state == WBIT || state == PRIMEC || state == RBIT) && ph[0];
  assign r_le  = state == LATCH || state == LOAD;
  assign ack   = state == DONE && !is_poll;
  assign busy  = state != IDLE && state != DONE && !is_poll;

  // next state and phase index; ph counts low/high half-phases inside the clocked states
  always_comb begin
    state_n = state;
    ph_n = ph;
    case (state)
      IDLE:   if (go) begin state_n = SETUP; ph_n = '0; end
      SETUP:  if (pd) state_n = r_rt ? LOAD : WBIT;
      WBIT:   if (pd) begin state_n = bits_last ? LATCH : WBIT; ph_n = ph + 1'b1; end
      LATCH:  if (pd) state_n = DONE;
      LOAD:   if (pd) state_n = PRIME == 0 ? RBIT : PRIMEC;
      PRIMEC: if (pd) begin state_n = prime_last ? RBIT : PRIMEC; ph_n = prime_last ? '0 : ph + 1'b1; end
      RBIT:   if (pd) begin state_n = bits_last ? DONE : RBIT; ph_n = ph + 1'b1; end
      DONE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // state, selects, write bit presentation at each low phase, read sampling at the end of each high phase
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      ph <= '0;
      sh <= '0;
      r_rt <= 1'b0;
      r_cd <= 1'b0;
      r_dout <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_n;
      ph <= ph_n;
      if (state == IDLE && go) begin
        r_rt <= go_rt;
        r_cd <= go_cd;
        sh <= go_wdata;
      end
      if (pd && state_n == WBIT && !ph_n[0]) begin
        r_dout <= sh[7];
        sh <= {sh[6:0], 1'b0};
      end
      if (pd && state == RBIT && ph[0]) sh <= {sh[6:0], r_din};
      if (last_sample && !is_poll) rdata <= {sh[6:0], r_din};
    end

`ifdef TIPI_LINK_POLL_EN
  logic pend, pend_rt, pend_cd, poll_due;
  logic [7:0] pend_wdata, last_tc, poll_cnt;
  assign go = req | pend | (poll_due & poll_en);
  assign {go_rt, go_cd} = pend ? {pend_rt, pend_cd} : req ? {rt, cd} : TC;
  assign go_wdata = pend ? pend_wdata : wdata;
  // poll scheduling, client request parked during a poll, and TC change detection
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      poll_cnt <= '0;
      poll_due <= 1'b0;
      is_poll <= 1'b0;
      pend <= 1'b0;
      pend_rt <= 1'b0;
      pend_cd <= 1'b0;
      pend_wdata <= '0;
      last_tc <= '0;
      tc_change <= 1'b0;
    end else begin
      poll_cnt <= poll_en ? poll_cnt + 8'd1 : 8'd0;
      if (poll_en && poll_cnt == 8'(POLL_INTERVAL - 1)) poll_due <= 1'b1;
      else if (state == IDLE && go && !req && !pend) poll_due <= 1'b0;
      if (state == IDLE && go) begin
        is_poll <= !req && !pend;
        pend <= 1'b0;
      end else if (req && is_poll && state != IDLE && !pend) begin
        pend <= 1'b1;
        pend_rt <= rt;
        pend_cd <= cd;
        pend_wdata <= wdata;
      end
      tc_change <= 1'b0;
      if (last_sample && is_poll) begin
        last_tc <= {sh[6:0], r_din};
        tc_change <= last_tc != {sh[6:0], r_din};
      end
    end
`else
  assign go = req;
  assign go_rt = rt;
  assign go_cd = cd;
  assign go_wdata = wdata;
  assign is_poll = 1'b0;
`endif
endmodule
